// File: rtl/mix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mix_pkg
// Purpose  : Shared types and constants for the 8-lane mixing sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mix_pkg;

   localparam int W  = 32;   // lane width
   localparam int NL = 8;    // lane count

   typedef logic [W-1:0]          lane_t;
   typedef logic [NL-1:0][W-1:0]  lanes_t;  // lane i at bits [W*i +: W]

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [1:0] {ADDK, CHAIN, XORSH, MULC} stage_e;

   localparam lane_t C_MUL [NL] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
   localparam lane_t C_ADD [NL] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};

   // Lane index modulo the lane count, sized for selecting a lane.
   function automatic logic [2:0] lidx(input int i);
      return 3'(i % NL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mix_round_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mix_round_sched_if
// Purpose  : Seed/result handshake bundle plus flush and busy sideband.
// Revision : 1.0 - initial release
// ============================================================================
interface mix_round_sched_if #(
   parameter int W  = 32,
   parameter int RW = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [8*W-1:0]    in_data;
   logic [RW-1:0]     in_rounds;
   logic              out_valid;
   logic              out_ready;
   logic [8*W-1:0]    out_data;
   logic              flush;
   logic              busy;

   modport master (
      output in_valid, in_data, in_rounds, out_ready, flush,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_rounds, out_ready, flush,
      output in_ready, out_valid, out_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/mix_stage.sv
`default_nettype none
// ============================================================================
// Module   : mix_stage
// Purpose  : Combinational evaluation of one mixing stage over all 8 lanes.
// Revision : 1.0 - initial release
// ============================================================================
module mix_stage
   import mix_pkg::*;
(
   input  lanes_t i_lanes,
   input  stage_e i_stage,
   output lanes_t o_lanes
);

   lanes_t w_t;

   // CHAIN and XORSH walk lanes in order so later lanes see updated ones.
   always_comb begin
      w_t = i_lanes;
      case (i_stage)
         ADDK:  for (int i = 0; i < NL; i++)
                   w_t[lidx(i)] = i_lanes[lidx(i)] + lane_t'(i);
         CHAIN: for (int i = 0; i < NL; i++)
                   w_t[lidx(i)] = w_t[lidx(i)] + w_t[lidx(i + 7)];
         XORSH: for (int i = 0; i < NL; i++)
                   w_t[lidx(i)] = w_t[lidx(i)] ^ (w_t[lidx(i + 3)] << 16);
         MULC:  for (int i = 0; i < NL; i++)
                   w_t[lidx(i)] = i_lanes[lidx(i)] * C_MUL[lidx(i)] + C_ADD[lidx(i)];
         default: w_t = i_lanes;
      endcase
   end

   assign o_lanes = w_t;

endmodule
`default_nettype wire

// File: rtl/mix_round_sched.sv
`default_nettype none
// ============================================================================
// Module   : mix_round_sched
// Purpose  : Paced, handshaked round sequencer applying one mixing stage per
//            cycle (ADDK, CHAIN, XORSH, MULC per round) to a 256-bit seed.
// Revision : 1.0 - initial release
// ============================================================================
module mix_round_sched
   import mix_pkg::*;
#(
   parameter int W  = mix_pkg::W,
   parameter int RW = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   mix_round_sched_if.slave bus
);

   state_e            r_state;
   stage_e            r_stage;
   logic [RW-1:0]     r_rcnt;
   lanes_t            r_lanes;
   logic [8*W-1:0]    r_out_data;
   logic              r_out_valid;
   logic              r_in_ready;
   logic              r_busy;
   lanes_t            w_next;

   mix_stage u_stage (
      .i_lanes (r_lanes),
      .i_stage (r_stage),
      .o_lanes (w_next)
   );

   // Sequencer FSM: accept, step stages, present result; flush overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_stage     <= ADDK;
         r_rcnt      <= '0;
         r_lanes     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else if (bus.flush) begin
         r_state     <= IDLE;
         r_stage     <= ADDK;
         r_rcnt      <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_lanes    <= bus.in_data;
                  r_rcnt     <= bus.in_rounds;
                  r_stage    <= ADDK;
                  r_in_ready <= 1'b0;
                  if (bus.in_rounds == '0) begin
                     r_state <= DONE;   // result is the seed, offered next cycle
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_lanes <= w_next;
               if (r_stage == MULC) begin
                  r_stage <= ADDK;
                  r_rcnt  <= r_rcnt - RW'(1);
                  if (r_rcnt == RW'(1)) begin
                     // Load the result directly so out_valid lands on the final edge.
                     r_state     <= DONE;
                     r_busy      <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_next;
                  end
               end else begin
                  r_stage <= stage_e'(r_stage + 2'd1);
               end
            end
            DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;   // zero-round path enters here unpresented
                  r_out_data  <= r_lanes;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mix_round_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_round_sched
// Purpose  : Self-checking bench for mix_round_sched against a behavioural
//            reference of the round function and handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_round_sched;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mix_round_sched_if #(.W(32), .RW(8)) bus ();

   mix_round_sched #(.W(32), .RW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [255:0] C_VEC1 = {32'h00BE02B0, 32'h008801EF, 32'h005B012F, 32'h018100C8,
                                      32'h00C40066, 32'h006E0039, 32'h0033001D, 32'h001A0011};
   localparam logic [255:0] C_SEQ  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};

   // Reference round function written straight from the stage definitions.
   function automatic logic [255:0] golden(input logic [255:0] seed, input int rounds);
      logic [31:0] o [8];
      logic [31:0] m [8];
      logic [31:0] a [8];
      logic [255:0] res;
      m = '{2, 3, 5, 7, 11, 13, 17, 19};
      a = '{3, 5, 7, 11, 13, 17, 19, 23};
      for (int i = 0; i < 8; i++) o[i] = seed[32*i +: 32];
      for (int r = 0; r < rounds; r++) begin
         for (int i = 0; i < 8; i++) o[i] = o[i] + 32'(i);
         for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i + 7) % 8];
         for (int i = 0; i < 8; i++) o[i] = o[i] ^ (o[(i + 3) % 8] << 16);
         for (int i = 0; i < 8; i++) o[i] = o[i] * m[i] + a[i];
      end
      for (int i = 0; i < 8; i++) res[32*i +: 32] = o[i];
      return res;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Behavioural model: 0 = ready for a job, 1 = job in flight, 2 = result offered.
   int           m_phase;
   int           m_left;
   logic         m_busy_job;
   logic [255:0] m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase    <= 0;
         m_left     <= 0;
         m_busy_job <= 1'b0;
         m_res      <= '0;
      end else if (bus.flush) begin
         m_phase    <= 0;
         m_busy_job <= 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
                  m_phase    <= 1;
                  m_left     <= (bus.in_rounds == 0) ? 1 : 4 * int'(bus.in_rounds);
                  m_busy_job <= (bus.in_rounds != 0);
                  m_res      <= golden(bus.in_data, int'(bus.in_rounds));
               end
            1: begin
                  if (m_left == 1) m_phase <= 2;
                  m_left <= m_left - 1;
               end
            2: if (bus.out_ready) m_phase <= 0;
            default: m_phase <= 0;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk1("in_ready", bus.in_ready, m_phase == 0);
         chk1("busy", bus.busy, (m_phase == 1) && m_busy_job);
         chk1("out_valid", bus.out_valid, m_phase == 2);
         if (m_phase == 2) chkw("out_data", bus.out_data, m_res);
      end
   end

   // One job: offer, measure latency, stall for hold cycles, then accept.
   task automatic run_job(input logic [255:0] seed, input int rounds, input int hold,
                          output logic [255:0] got);
      int lat;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = seed;
      bus.in_rounds = 8'(rounds);
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 1100) begin
         bus.in_data   = {8{$urandom}};
         bus.in_rounds = 8'($urandom);
         @(negedge clk);
         lat++;
      end
      chki("latency", lat, (rounds == 0) ? 1 : 4 * rounds);
      got = bus.out_data;
      repeat (hold) @(negedge clk);
      chkw("held_data", bus.out_data, got);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk1("in_ready_after", bus.in_ready, 1'b1);
   endtask

   logic [255:0] got;

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_rounds = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chkw("rst_out_data", bus.out_data, '0);
      rst_n = 1'b1;

      // Known vector, one round.
      run_job('0, 1, 0, got);
      chkw("vec1", got, C_VEC1);
      chkw("model_vec1", golden('0, 1), C_VEC1);

      // Zero rounds passes the seed through.
      run_job(C_SEQ, 0, 2, got);
      chkw("zero_rounds", got, C_SEQ);

      // Backpressure for ten cycles.
      run_job({8{32'hDEADBEEF}}, 1, 10, got);

      // Flush in the third RUN cycle of a five-round job.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = {8{32'h12345678}};
      bus.in_rounds = 8'd5;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk1("flush_busy", bus.busy, 1'b0);
      chk1("flush_in_ready", bus.in_ready, 1'b1);
      chk1("flush_out_valid", bus.out_valid, 1'b0);
      repeat (25) @(negedge clk);
      run_job('0, 1, 0, got);
      chkw("vec1_after_flush", got, C_VEC1);

      // Flush together with in_valid in IDLE must not accept.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_rounds = 8'd2;
      bus.flush     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk1("flush_no_accept", bus.in_ready, 1'b1);

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = {8{32'hA5A5A5A5}};
      bus.in_rounds = 8'd3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("arst_in_ready", bus.in_ready, 1'b1);
      chk1("arst_out_valid", bus.out_valid, 1'b0);
      chk1("arst_busy", bus.busy, 1'b0);
      chkw("arst_out_data", bus.out_data, '0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_job({8{32'h0BADF00D}}, 2, 1, got);

      // Random seeds and round counts, plus the maximum count.
      for (int k = 0; k < 10; k++) begin
         run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 int'($urandom_range(1, 255)), int'($urandom_range(0, 3)), got);
      end
      run_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              255, 1, got);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
